// File: rtl/register_pkg.sv
// Shared function-select encodings for the register block and its bench.
package register_pkg;

    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;
    localparam logic [1:0] FS_DEC   = 2'b10;
    localparam logic [1:0] FS_INC   = 2'b11;

endpackage

// File: rtl/register.sv
// Loadable up/down register: clear, load, decrement or increment when enabled.
module register
    import register_pkg::*;
#(
    parameter int NBits = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       funsel,
    input  logic             e,
    input  logic [NBits-1:0] i,
    output logic [NBits-1:0] q
);

    logic [NBits-1:0] nxt;

    // Unknown e or funsel falls to the default arms so simulation shows X on q.
    always_comb begin
        nxt = q;
        case (e)
            1'b0: nxt = q;
            1'b1: begin
                case (funsel)
                    FS_CLEAR: nxt = '0;
                    FS_LOAD:  nxt = i;
                    FS_DEC:   nxt = q - NBits'(1);
                    FS_INC:   nxt = q + NBits'(1);
                    default:  nxt = 'x;
                endcase
            end
            default: nxt = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: tb/tb_register.sv
// Self-checking bench for register: directed corner sequences plus randomized traffic.
module tb_register;
    import register_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         e      = 1'b0;
    logic [1:0]   funsel = FS_CLEAR;
    logic [W-1:0] i      = '0;
    logic [W-1:0] q;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    register #(.NBits(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .funsel (funsel),
        .e      (e),
        .i      (i),
        .q      (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain modular arithmetic on an integer value.
    function automatic int ref_next(int cur, logic en, logic [1:0] fs, logic [W-1:0] d);
        if (!en) return cur;
        case (fs)
            FS_CLEAR: return 0;
            FS_LOAD:  return int'(d);
            FS_DEC:   return (cur + MOD - 1) % MOD;
            default:  return (cur + 1) % MOD;
        endcase
    endfunction

    task automatic step(input string tag, input logic en, input logic [1:0] fs, input logic [W-1:0] d);
        e      = en;
        funsel = fs;
        i      = d;
        @(posedge clk);
        #1;
        if (rst) model = 0;
        else     model = ref_next(model, en, fs, d);
        check(tag, q, W'(model));
    endtask

    logic [W-1:0] load_vals [5] = '{4'b1111, 4'b1010, 4'b0001, 4'b0110, 4'b0000};

    initial begin
        #3;
        check("reset_async", q, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", q, '0);
        rst   = 1'b0;
        model = 0;

        foreach (load_vals[k]) begin
            step("load", 1'b1, FS_LOAD, load_vals[k]);
            step("clear", 1'b1, FS_CLEAR, 4'($urandom));
        end

        step("inc_start_clear", 1'b1, FS_CLEAR, '0);
        for (int k = 0; k < 17; k++) step("inc_wrap", 1'b1, FS_INC, 4'($urandom));

        step("dec_start_clear", 1'b1, FS_CLEAR, '0);
        step("dec_first", 1'b1, FS_DEC, '0);
        check("dec_underflow", q, 4'b1111);
        for (int k = 0; k < 16; k++) step("dec_wrap", 1'b1, FS_DEC, 4'($urandom));
        check("dec_back_to_ones", q, 4'b1111);

        for (int k = 0; k < 12; k++) step("enable_gate", logic'(k % 2 == 0), FS_INC, 4'($urandom));

        step("pre_reset_load", 1'b1, FS_LOAD, 4'b1010);
        check("pre_reset_value", q, 4'b1010);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_midcycle", q, '0);
        step("reset_beats_load", 1'b1, FS_LOAD, 4'b1111);
        #2;
        rst = 1'b0;
        step("release_load", 1'b1, FS_LOAD, 4'b0110);
        check("release_value", q, 4'b0110);

        // Random traffic with between-edge input noise and occasional async reset pulses.
        for (int k = 0; k < 300; k++) begin
            #1;
            e      = 1'($urandom);
            funsel = 2'($urandom);
            i      = 4'($urandom);
            #1;
            check("mid_cycle_stable", q, W'(model));
            if ($urandom_range(0, 31) == 0) begin
                rst = 1'b1;
                #1;
                check("rand_async_reset", q, '0);
                rst   = 1'b0;
                model = 0;
            end
            step("random", 1'($urandom), 2'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
